// File: rtl/emu_ckpt_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : emu_ckpt_scan_ctrl
// Description : Checkpoint scan sequencer for an emulated DUT. Pauses the DUT
//               clocks, walks the FF scan chain and then the RAM scan chain,
//               streaming chain words out (dump) or in (restore) over 64-bit
//               valid/ready streams.
// Ports       : emu_host_clk/emu_host_rst - clock, sync active-high reset
//               cmd_valid/cmd_dir/cmd_ready - start request (dir 1 = restore)
//               busy/done                   - status, done is a 1-cycle pulse
//               emu_pause, emu_ff_*         - DUT clock gate and FF chain
//               emu_ram_*                   - DUT RAM scan chain
//               out_valid/out_ready/out_data - dump stream
//               in_valid/in_ready/in_data    - restore stream
// Revision    : 1.0 - initial release
// ============================================================================
module emu_ckpt_scan_ctrl #(
    parameter int FF_WORDS  = 8,
    parameter int MEM_WORDS = 16,
    parameter int RAM_LAT   = 2,
    parameter int CNT_W     = 16
) (
    input  logic        emu_host_clk,
    input  logic        emu_host_rst,
    input  logic        cmd_valid,
    input  logic        cmd_dir,
    output logic        cmd_ready,
    output logic        busy,
    output logic        done,
    output logic        emu_pause,
    output logic        emu_ff_se,
    output logic        emu_ff_dir,
    output logic [63:0] emu_ff_sdi,
    input  logic [63:0] emu_ff_do,
    output logic        emu_ram_se,
    output logic        emu_ram_sd,
    output logic [63:0] emu_ram_di,
    input  logic [63:0] emu_ram_do,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data
);

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_PAUSE    = 3'd1;
    localparam logic [2:0] c_ST_FF       = 3'd2;
    localparam logic [2:0] c_ST_RAM_PRE  = 3'd3;
    localparam logic [2:0] c_ST_RAM      = 3'd4;
    localparam logic [2:0] c_ST_RAM_POST = 3'd5;
    localparam logic [2:0] c_ST_RESUME   = 3'd6;

    localparam int c_PTR_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int c_OCC_W = $clog2(MEM_WORDS + 1);

    localparam logic [CNT_W-1:0]   c_FF_LAST  = CNT_W'(FF_WORDS - 1);
    localparam logic [CNT_W-1:0]   c_MEM_LAST = CNT_W'(MEM_WORDS - 1);
    localparam logic [CNT_W-1:0]   c_PRE_LAST = CNT_W'(RAM_LAT - 1);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(MEM_WORDS - 1);
    localparam logic [c_OCC_W-1:0] c_OCC_ONE  = c_OCC_W'(1);

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_dir;
    logic               r_done;
    logic               w_done_nxt;
    logic               w_beat;
    logic               w_push;
    logic               w_pop;

    // Dump-side RAM FIFO: the RAM chain cannot stall on read, so words are
    // buffered here while the output stream drains at its own pace.
    logic [63:0]        r_fifo [MEM_WORDS];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_OCC_W-1:0] r_occ;

    assign done = r_done;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        w_beat      = 1'b0;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        cmd_ready   = 1'b0;
        busy        = 1'b1;
        emu_pause   = 1'b1;
        emu_ff_se   = 1'b0;
        emu_ff_dir  = 1'b0;
        emu_ff_sdi  = '0;
        emu_ram_se  = 1'b0;
        emu_ram_sd  = 1'b0;
        emu_ram_di  = '0;
        out_valid   = 1'b0;
        out_data    = '0;
        in_ready    = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                emu_pause = 1'b0;
                if (cmd_valid) begin
                    w_state_nxt = c_ST_PAUSE;
                end
            end

            // One quiet paused cycle so the gated clock settles before shifting.
            c_ST_PAUSE: begin
                w_cnt_nxt   = '0;
                w_state_nxt = c_ST_FF;
            end

            c_ST_FF: begin
                if (!r_dir) begin
                    // Loop-back shift: after FF_WORDS beats the chain is back
                    // in its original state.
                    out_valid = 1'b1;
                    out_data  = emu_ff_do;
                    emu_ff_se = out_ready;
                    w_beat    = out_ready;
                end else begin
                    emu_ff_dir = 1'b1;
                    emu_ff_sdi = in_data;
                    in_ready   = 1'b1;
                    emu_ff_se  = in_valid;
                    w_beat     = in_valid;
                end
                if (w_beat) begin
                    if (r_cnt == c_FF_LAST) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = (r_dir || (RAM_LAT == 0)) ? c_ST_RAM : c_ST_RAM_PRE;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end

            // Prime the RAM read pipeline; nothing is captured yet.
            c_ST_RAM_PRE: begin
                emu_ram_se = 1'b1;
                if (r_cnt == c_PRE_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_ST_RAM;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            c_ST_RAM: begin
                if (!r_dir) begin
                    emu_ram_se = 1'b1;
                    w_push     = 1'b1;
                    out_valid  = (r_occ != '0);
                    out_data   = r_fifo[r_rptr];
                    w_pop      = out_valid && out_ready;
                    w_beat     = 1'b1;
                end else begin
                    emu_ram_sd = 1'b1;
                    emu_ram_di = in_data;
                    in_ready   = 1'b1;
                    emu_ram_se = in_valid;
                    w_beat     = in_valid;
                end
                if (w_beat) begin
                    if (r_cnt == c_MEM_LAST) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = c_ST_RAM_POST;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end

            c_ST_RAM_POST: begin
                if (!r_dir) begin
                    out_valid = (r_occ != '0);
                    out_data  = r_fifo[r_rptr];
                    w_pop     = out_valid && out_ready;
                    // Leave as soon as the last buffered beat is accepted.
                    if ((r_occ == '0) || ((r_occ == c_OCC_ONE) && out_ready)) begin
                        w_state_nxt = c_ST_RESUME;
                    end
                end else begin
                    // The RAM writes one step behind its input; this extra
                    // load cycle commits the final restored word.
                    emu_ram_se  = 1'b1;
                    emu_ram_sd  = 1'b1;
                    w_state_nxt = c_ST_RESUME;
                end
            end

            c_ST_RESUME: begin
                w_done_nxt  = 1'b1;
                w_state_nxt = c_ST_IDLE;
            end

            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge emu_host_clk) begin
        if (emu_host_rst) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            r_dir   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
            if ((r_state == c_ST_IDLE) && cmd_valid) begin
                r_dir <= cmd_dir;
            end
        end
    end

    always_ff @(posedge emu_host_clk) begin
        if (w_push) begin
            r_fifo[r_wptr] <= emu_ram_do;
        end
    end

    always_ff @(posedge emu_host_clk) begin
        if (emu_host_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_occ  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= (r_wptr == c_PTR_LAST) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == c_PTR_LAST) ? '0 : r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_emu_ckpt_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_emu_ckpt_scan_ctrl
// Description : Self-checking bench for emu_ckpt_scan_ctrl with a behavioural
//               model of the DUT FF chain and RAM scan chain, and a scoreboard
//               of expected dump words.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_emu_ckpt_scan_ctrl;

    localparam int FFW = 2;
    localparam int MW  = 4;
    localparam int RL  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_dir, cmd_ready, busy, done;
    logic        emu_pause, emu_ff_se, emu_ff_dir, emu_ram_se, emu_ram_sd;
    logic [63:0] emu_ff_sdi, emu_ff_do, emu_ram_di, emu_ram_do;
    logic        out_valid, out_ready, in_valid, in_ready;
    logic [63:0] out_data, in_data;

    always #5 clk = ~clk;

    emu_ckpt_scan_ctrl #(
        .FF_WORDS (FFW),
        .MEM_WORDS(MW),
        .RAM_LAT  (RL),
        .CNT_W    (16)
    ) u_dut (
        .emu_host_clk(clk),
        .emu_host_rst(rst),
        .cmd_valid   (cmd_valid),
        .cmd_dir     (cmd_dir),
        .cmd_ready   (cmd_ready),
        .busy        (busy),
        .done        (done),
        .emu_pause   (emu_pause),
        .emu_ff_se   (emu_ff_se),
        .emu_ff_dir  (emu_ff_dir),
        .emu_ff_sdi  (emu_ff_sdi),
        .emu_ff_do   (emu_ff_do),
        .emu_ram_se  (emu_ram_se),
        .emu_ram_sd  (emu_ram_sd),
        .emu_ram_di  (emu_ram_di),
        .emu_ram_do  (emu_ram_do),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data)
    );

    // ---------------- EMU_DUT scan model ----------------
    logic [63:0] init_ff  [FFW];
    logic [63:0] init_mem [MW];
    logic        model_load;
    logic [63:0] ff_chain [FFW];
    logic [63:0] mem      [MW];
    logic [63:0] rd_pipe  [RL];
    int          rd_addr;
    int          wr_cnt;
    logic [63:0] wr_hold;

    assign emu_ff_do  = ff_chain[FFW-1];
    assign emu_ram_do = rd_pipe[RL-1];

    always @(posedge clk) begin
        if (model_load) begin
            for (int i = 0; i < FFW; i++) ff_chain[i] <= init_ff[i];
            for (int i = 0; i < MW; i++)  mem[i]      <= init_mem[i];
            rd_addr <= 0;
            wr_cnt  <= 0;
            wr_hold <= '0;
        end else begin
            if (emu_ff_se) begin
                ff_chain[0] <= emu_ff_dir ? emu_ff_sdi : emu_ff_do;
                for (int i = 1; i < FFW; i++) ff_chain[i] <= ff_chain[i-1];
            end
            if (!emu_pause) begin
                rd_addr <= 0;
                wr_cnt  <= 0;
            end else if (emu_ram_se && !emu_ram_sd) begin
                rd_pipe[0] <= mem[rd_addr % MW];
                rd_addr    <= rd_addr + 1;
            end else if (emu_ram_se && emu_ram_sd) begin
                // Writes lag one load cycle behind the presented data.
                if (wr_cnt > 0 && wr_cnt <= MW) mem[wr_cnt-1] <= wr_hold;
                wr_hold <= emu_ram_di;
                wr_cnt  <= wr_cnt + 1;
            end
            for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
        end
    end

    // ---------------- checking ----------------
    int n_pass = 0;
    int n_chk  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    logic [63:0] exp_q [$];
    logic [63:0] cap_q [$];
    logic [63:0] rq    [$];
    logic [63:0] saved [$];

    int s_ff, s_ram, s_pause, s_beats, s_done, s_commit, s_err;

    // Runs one command; pat 0 = ready/valid always, 1 = ready toggling,
    // 2 = valid every third cycle. poke asserts cmd_valid while busy.
    task automatic run_op(input logic dir, input int pat, input bit poke);
        int cyc;
        bit vld;
        int gap;
        bit fin;
        s_ff = 0; s_ram = 0; s_pause = 0; s_beats = 0;
        s_done = 0; s_commit = 0; s_err = 0;
        cap_q.delete();
        if (!dir) begin
            exp_q.delete();
            for (int i = 0; i < FFW; i++) exp_q.push_back(ff_chain[FFW-1-i]);
            for (int i = 0; i < MW; i++)  exp_q.push_back(mem[i]);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_dir   = dir;
        @(negedge clk);
        chk("cmd_ready_idle", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cyc = 0; vld = 0; gap = 0; fin = 0;
        while (!fin) begin
            if (!dir) begin
                out_ready = (pat == 1) ? (cyc % 2 == 0) : 1'b1;
                in_valid  = 1'b0;
            end else begin
                out_ready = 1'b0;
                if (!vld && rq.size() > 0) begin
                    if (pat != 2 || gap >= 2) vld = 1;
                    else gap++;
                end
                in_valid = vld;
                in_data  = vld ? rq[0] : '0;
            end
            cmd_valid = poke && (cyc >= 3) && (cyc < 6);
            @(negedge clk);
            if (poke && cyc >= 3 && cyc < 6) chk("cmd_ready_busy", cmd_ready, 0);
            s_ff     += int'(emu_ff_se);
            s_ram    += int'(emu_ram_se);
            s_pause  += int'(emu_pause);
            s_done   += int'(done);
            if (out_valid && out_ready) begin
                s_beats++;
                cap_q.push_back(out_data);
                if (exp_q.size() > 0) chk("dump_data", out_data, exp_q.pop_front());
            end
            if (dir) begin
                if ((emu_ff_se || (emu_ram_se && in_ready)) !== (in_valid && in_ready)) s_err++;
                if (emu_ram_se && emu_ram_sd && !in_ready) begin
                    s_commit++;
                    if (emu_ram_di !== 64'd0) s_err++;
                end
                if (out_valid) s_err++;
                if (in_valid && in_ready) begin
                    s_beats++;
                    void'(rq.pop_front());
                    vld = 0;
                    gap = 0;
                end
            end else begin
                if (emu_ff_se && !(out_valid && out_ready)) s_err++;
                if (in_ready) s_err++;
            end
            if (done) fin = 1;
            cyc++;
            if (!fin && cyc > 300) begin
                chk("op_timeout", done, 1);
                fin = 1;
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        cmd_valid = 1'b0;
        repeat (8) begin
            @(negedge clk);
            s_done += int'(done);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        rst = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0;
        out_ready = 1'b0; in_valid = 1'b0; in_data = '0;
        model_load = 1'b0;
        init_ff[0] = 64'h1111_2222_3333_4444;
        init_ff[1] = 64'hAAAA_BBBB_CCCC_DDDD;
        init_mem[0] = 64'h0000_0000_0000_0A00;
        init_mem[1] = 64'h0000_0000_DEAD_BEEF;
        init_mem[2] = 64'h0123_4567_89AB_CDEF;
        init_mem[3] = 64'hFEDC_BA98_7654_3210;
        model_load = 1'b1;
        repeat (3) @(posedge clk);
        #1 model_load = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pause", emu_pause, 0);
        chk("rst_se", {emu_ff_se, emu_ram_se}, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_data", out_data, 0);
        @(posedge clk); #1 rst = 1'b0;

        // dump, ready held, with command pokes while busy
        run_op(1'b0, 0, 1'b1);
        chk("A_beats", s_beats, 6);
        chk("A_ff_se", s_ff, 2);
        chk("A_ram_se", s_ram, 6);
        chk("A_pause", s_pause, 11);
        chk("A_done", s_done, 1);
        chk("A_proto", s_err, 0);
        for (int i = 0; i < FFW; i++) chk("A_ff_kept", ff_chain[i], init_ff[i]);
        saved = cap_q;

        // dump with toggling ready; scoreboard compares against same data
        run_op(1'b0, 1, 1'b0);
        chk("B_beats", s_beats, 6);
        chk("B_ff_se", s_ff, 2);
        chk("B_done", s_done, 1);
        chk("B_proto", s_err, 0);
        for (int i = 0; i < 6; i++) chk("B_vs_ref", cap_q[i], saved[i]);

        // clobber DUT state, then restore with gapped valid
        for (int i = 0; i < FFW; i++) init_ff[i] = '0;
        for (int i = 0; i < MW; i++)  init_mem[i] = '0;
        @(posedge clk); #1 model_load = 1'b1;
        @(posedge clk); #1 model_load = 1'b0;
        chk("clobbered", mem[1], 0);
        rq = saved;
        run_op(1'b1, 2, 1'b0);
        chk("C_beats", s_beats, 6);
        chk("C_ff_se", s_ff, 2);
        chk("C_ram_se", s_ram, 5);
        chk("C_commit", s_commit, 1);
        chk("C_track", s_err, 0);
        chk("C_done", s_done, 1);
        chk("C_mem1", mem[1], 64'h0000_0000_DEAD_BEEF);
        for (int i = 0; i < MW; i++)  chk("C_mem", mem[i], saved[FFW+i]);
        chk("C_ff1", ff_chain[1], 64'hAAAA_BBBB_CCCC_DDDD);
        chk("C_ff0", ff_chain[0], 64'h1111_2222_3333_4444);

        // reset in the middle of the RAM dump
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_dir = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1 cmd_valid = 1'b0;
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (emu_ram_se) found = 1;
        end
        chk("D_reach_ram", emu_ram_se, 1);
        @(posedge clk); #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("D_cmd_ready", cmd_ready, 1);
        chk("D_pause", emu_pause, 0);
        chk("D_se", {emu_ff_se, emu_ram_se}, 0);
        chk("D_out_valid", out_valid, 0);
        @(posedge clk); #1 rst = 1'b0;
        // stale FIFO contents would corrupt the RAM words of this dump
        run_op(1'b0, 0, 1'b0);
        chk("E_beats", s_beats, 6);
        chk("E_done", s_done, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
